cv32e40p_retire_trace_buffer: RTL and testbench

Parametrised on-chip retirement trace buffer for cv32e40p, the synthesisable successor to simulation-only execution tracing. It captures one record per retired instruction from the core's ID/WB observation points into a DEPTH-entry circular store. A debug or host agent drains the store over a valid/ready port. Three capture modes (stream, stop-on-full, wrap) and a saturating drop counter make it usable both for live streaming and for post-mortem "last N instructions" capture.

---
 rtl/cv32e40p_trace_pkg.sv | 43 ++++
 rtl/cv32e40p_trace_ram.sv | 27 ++
 rtl/cv32e40p_retire_trace_buffer.sv | 220 ++++++++++++++++++++++
 tb/tb_cv32e40p_retire_trace_buffer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_trace_pkg.sv
// Shared types and constants for the cv32e40p retirement trace buffer.
package cv32e40p_trace_pkg;

  // Field widths of one trace record. The buffer's ADDR_WIDTH and DATA_WIDTH
  // parameters are expected to match these.
  localparam int unsigned TRACE_ADDR_WIDTH = 32;
  localparam int unsigned TRACE_DATA_WIDTH = 32;
  localparam int unsigned TRACE_RD_WIDTH   = 6;
  localparam int unsigned TRACE_FLAG_WIDTH = 3;

  // Bit positions inside trace_rec_t.flags ({compressed, illegal, debug_mode}).
  localparam int unsigned TRACE_FLAG_DEBUG      = 0;
  localparam int unsigned TRACE_FLAG_ILLEGAL    = 1;
  localparam int unsigned TRACE_FLAG_COMPRESSED = 2;

  typedef enum logic [1:0] {
    TRACE_STREAM = 2'd0,
    TRACE_STOP   = 2'd1,
    TRACE_WRAP   = 2'd2
  } trace_mode_e;

  typedef struct packed {
    logic [TRACE_ADDR_WIDTH-1:0] pc;
    logic [TRACE_DATA_WIDTH-1:0] instr;
    logic [TRACE_RD_WIDTH-1:0]   rd;
    logic                        we;
    logic [TRACE_DATA_WIDTH-1:0] wdata;
    logic [TRACE_FLAG_WIDTH-1:0] flags;
  } trace_rec_t;

  // Map the raw mode input onto a capture mode; the unused encoding behaves as stream.
  function automatic trace_mode_e decode_mode(input logic [1:0] mode);
    trace_mode_e m;
    case (mode)
      2'd0:    m = TRACE_STREAM;
      2'd1:    m = TRACE_STOP;
      2'd2:    m = TRACE_WRAP;
      default: m = TRACE_STREAM;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/cv32e40p_trace_ram.sv
// Trace record storage: one synchronous write port, one asynchronous read port.
// Deliberately not reset so it can be swapped for a latch array or SRAM macro.
module cv32e40p_trace_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Write port: store a record when enabled.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_r[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_r[raddr_i];

endmodule

// File: rtl/cv32e40p_retire_trace_buffer.sv
// Retirement trace buffer: captures one record per retired instruction into a
// circular store and lets a consumer drain it over a valid/ready port.
module cv32e40p_retire_trace_buffer
  import cv32e40p_trace_pkg::*;
#(
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned DROP_CNT_WIDTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       enable_i,
  input  logic                       clear_i,
  input  logic [1:0]                 mode_i,
  input  logic                       retire_valid_i,
  input  logic [ADDR_WIDTH-1:0]      retire_pc_i,
  input  logic [DATA_WIDTH-1:0]      retire_instr_i,
  input  logic [5:0]                 retire_rd_i,
  input  logic                       retire_we_i,
  input  logic [DATA_WIDTH-1:0]      retire_wdata_i,
  input  logic [2:0]                 retire_flags_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output trace_rec_t                 out_rec_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       stopped_o,
  output logic [DROP_CNT_WIDTH-1:0]  drop_cnt_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
  localparam int unsigned REC_W = $bits(trace_rec_t);

  localparam logic [LVL_W-1:0]          FULL_LVL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0]          LVL_ONE  = LVL_W'(1);
  localparam logic [LVL_W-1:0]          LVL_ZERO = LVL_W'(0);
  localparam logic [PTR_W-1:0]          PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0]          PTR_ZERO = PTR_W'(0);
  localparam logic [DROP_CNT_WIDTH-1:0] DROP_MAX = {DROP_CNT_WIDTH{1'b1}};
  localparam logic [DROP_CNT_WIDTH-1:0] DROP_ONE = DROP_CNT_WIDTH'(1);

  // State registers
  logic [PTR_W-1:0]          wptr_r, rptr_r;
  logic [LVL_W-1:0]          level_r;
  logic [DROP_CNT_WIDTH-1:0] drop_r;
  logic                      stopped_r;
  logic                      valid_r;

  // Next-state values
  logic [PTR_W-1:0]          wptr_nxt_s, rptr_nxt_s;
  logic [LVL_W-1:0]          level_nxt_s;
  logic [DROP_CNT_WIDTH-1:0] drop_nxt_s;
  logic                      stopped_nxt_s;
  logic                      valid_nxt_s;

  // Per-cycle decisions
  trace_mode_e mode_s;
  logic        retire_s;
  logic        push_s;
  logic        pop_s;
  logic        full_s;
  logic        wr_en_s;
  logic        wrap_ovw_s;
  logic        drop_inc_s;
  logic        set_stop_s;
  logic        lvl_up_s;
  trace_rec_t  wr_rec_s;
  trace_rec_t  rd_rec_s;

  assign mode_s   = decode_mode(mode_i);
  assign retire_s = retire_valid_i & enable_i;
  assign push_s   = retire_s & ~stopped_r;
  assign pop_s    = valid_r & out_ready_i;
  assign full_s   = (level_r == FULL_LVL);

  // Pack the retirement observation into a trace record.
  always_comb begin
    wr_rec_s       = {REC_W{1'b0}};
    wr_rec_s.pc    = retire_pc_i;
    wr_rec_s.instr = retire_instr_i;
    wr_rec_s.rd    = retire_rd_i;
    wr_rec_s.we    = retire_we_i;
    wr_rec_s.wdata = retire_wdata_i;
    wr_rec_s.flags = retire_flags_i;
  end

  // Decide whether this cycle's retirement is stored, overwrites, or is dropped.
  // A full store with a simultaneous pop always has room. Retirements that arrive
  // while capture is frozen are lost, so they count as drops as well.
  always_comb begin
    wr_en_s    = 1'b0;
    wrap_ovw_s = 1'b0;
    drop_inc_s = 1'b0;
    set_stop_s = 1'b0;
    if (clear_i) begin
      wr_en_s = 1'b0;
    end else if (push_s) begin
      if (!full_s || pop_s) begin
        wr_en_s = 1'b1;
      end else begin
        case (mode_s)
          TRACE_WRAP: begin
            wr_en_s    = 1'b1;
            wrap_ovw_s = 1'b1;
            drop_inc_s = 1'b1;
          end
          TRACE_STOP: begin
            drop_inc_s = 1'b1;
            set_stop_s = 1'b1;
          end
          TRACE_STREAM: begin
            drop_inc_s = 1'b1;
          end
          default: begin
            drop_inc_s = 1'b1;
          end
        endcase
      end
    end else if (retire_s) begin
      drop_inc_s = 1'b1;
    end else begin
      drop_inc_s = 1'b0;
    end
  end

  // An overwrite in wrap mode replaces the oldest entry, so occupancy does not grow.
  assign lvl_up_s = wr_en_s & ~wrap_ovw_s;

  // Compute next pointers, occupancy, drop count and stop flag; clear wins over everything.
  always_comb begin
    wptr_nxt_s    = wptr_r;
    rptr_nxt_s    = rptr_r;
    level_nxt_s   = level_r;
    drop_nxt_s    = drop_r;
    stopped_nxt_s = stopped_r;
    if (clear_i) begin
      wptr_nxt_s    = PTR_ZERO;
      rptr_nxt_s    = PTR_ZERO;
      level_nxt_s   = LVL_ZERO;
      drop_nxt_s    = {DROP_CNT_WIDTH{1'b0}};
      stopped_nxt_s = 1'b0;
    end else begin
      if (wr_en_s) begin
        wptr_nxt_s = wptr_r + PTR_ONE;
      end else begin
        wptr_nxt_s = wptr_r;
      end

      if (pop_s || wrap_ovw_s) begin
        rptr_nxt_s = rptr_r + PTR_ONE;
      end else begin
        rptr_nxt_s = rptr_r;
      end

      if (lvl_up_s && !pop_s) begin
        level_nxt_s = level_r + LVL_ONE;
      end else if (!lvl_up_s && pop_s) begin
        level_nxt_s = level_r - LVL_ONE;
      end else begin
        level_nxt_s = level_r;
      end

      if (drop_inc_s && (drop_r != DROP_MAX)) begin
        drop_nxt_s = drop_r + DROP_ONE;
      end else begin
        drop_nxt_s = drop_r;
      end

      if (set_stop_s) begin
        stopped_nxt_s = 1'b1;
      end else begin
        stopped_nxt_s = stopped_r;
      end
    end
  end

  assign valid_nxt_s = (level_nxt_s != LVL_ZERO);

  // Control state register with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_r    <= PTR_ZERO;
      rptr_r    <= PTR_ZERO;
      level_r   <= LVL_ZERO;
      drop_r    <= {DROP_CNT_WIDTH{1'b0}};
      stopped_r <= 1'b0;
      valid_r   <= 1'b0;
    end else begin
      wptr_r    <= wptr_nxt_s;
      rptr_r    <= rptr_nxt_s;
      level_r   <= level_nxt_s;
      drop_r    <= drop_nxt_s;
      stopped_r <= stopped_nxt_s;
      valid_r   <= valid_nxt_s;
    end
  end

  cv32e40p_trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W),
    .AW    (PTR_W)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (wr_en_s),
    .waddr_i (wptr_r),
    .wdata_i (wr_rec_s),
    .raddr_i (rptr_r),
    .rdata_o (rd_rec_s)
  );

  // The payload store is not reset; masking with the registered valid keeps the
  // record output at zero whenever nothing is held.
  assign out_rec_o   = valid_r ? rd_rec_s : trace_rec_t'({REC_W{1'b0}});
  assign out_valid_o = valid_r;
  assign level_o     = level_r;
  assign stopped_o   = stopped_r;
  assign drop_cnt_o  = drop_r;

endmodule

// File: tb/tb_cv32e40p_retire_trace_buffer.sv
// Self-checking bench for cv32e40p_retire_trace_buffer (DEPTH=4). A second
// instance with a 2-bit drop counter shares all inputs to cover saturation.
module tb_cv32e40p_retire_trace_buffer;
  import cv32e40p_trace_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en, clr, rv, we, rdy;
  logic [1:0]  mode;
  logic [31:0] pc, instr, wdata;
  logic [5:0]  rd;
  logic [2:0]  flags;

  logic        va, vb, stpa, stpb;
  trace_rec_t  reca, recb;
  logic [2:0]  lvla, lvlb;
  logic [15:0] dropa;
  logic [1:0]  dropb;

  cv32e40p_retire_trace_buffer #(.DEPTH(4)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .clear_i(clr), .mode_i(mode),
    .retire_valid_i(rv), .retire_pc_i(pc), .retire_instr_i(instr), .retire_rd_i(rd),
    .retire_we_i(we), .retire_wdata_i(wdata), .retire_flags_i(flags),
    .out_valid_o(va), .out_ready_i(rdy), .out_rec_o(reca), .level_o(lvla),
    .stopped_o(stpa), .drop_cnt_o(dropa)
  );

  cv32e40p_retire_trace_buffer #(.DEPTH(4), .DROP_CNT_WIDTH(2)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .clear_i(clr), .mode_i(mode),
    .retire_valid_i(rv), .retire_pc_i(pc), .retire_instr_i(instr), .retire_rd_i(rd),
    .retire_we_i(we), .retire_wdata_i(wdata), .retire_flags_i(flags),
    .out_valid_o(vb), .out_ready_i(rdy), .out_rec_o(recb), .level_o(lvlb),
    .stopped_o(stpb), .drop_cnt_o(dropb)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model / scoreboard
  trace_rec_t q[$];
  int         m_drop = 0;
  bit         m_stop = 1'b0;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        rdy;
    logic [1:0]  md;
    logic        clr;
    logic        en;
    int          e_lvl;
    int          e_drop;
    logic        e_stop;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic trace_rec_t mk_rec(input logic [31:0] p);
    trace_rec_t r;
    r.pc    = p;
    r.instr = p ^ 32'h00A5_5A13;
    r.rd    = p[7:2];
    r.we    = p[2];
    r.wdata = ~p;
    r.flags = p[4:2];
    return r;
  endfunction

  function automatic void add(input logic v, input logic [31:0] p, input logic r,
                              input logic [1:0] md, input logic c, input logic e,
                              input int lv, input int dr, input logic st);
    vec_t x;
    x.v = v; x.pc = p; x.rdy = r; x.md = md; x.clr = c; x.en = e;
    x.e_lvl = lv; x.e_drop = dr; x.e_stop = st;
    vecs.push_back(x);
  endfunction

  task automatic check_state();
    int db;
    db = (m_drop > 3) ? 3 : m_drop;
    chk("level_a", lvla, q.size());
    chk("valid_a", va, q.size() != 0);
    chk("drop_a", dropa, m_drop);
    chk("stop_a", stpa, m_stop);
    chk("level_b", lvlb, q.size());
    chk("drop_b", dropb, db);
    if (q.size() != 0) begin
      chk("head_a", reca, q[0]);
      chk("head_b", recb, q[0]);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, {va, vb}, 2'b00);
    chk({tag, "_rec_a"}, reca, 0);
    chk({tag, "_rec_b"}, recb, 0);
    chk({tag, "_level"}, {lvla, lvlb}, 6'd0);
    chk({tag, "_stop"}, {stpa, stpb}, 2'b00);
    chk({tag, "_drop"}, {dropa, dropb}, 18'd0);
  endtask

  // One clock cycle: drive inputs, score the handshake, advance the model, check.
  task automatic step(input logic v, input logic [31:0] p, input logic r,
                      input logic [1:0] md, input logic c, input logic e);
    trace_rec_t rec;
    bit mpop, full;
    rec = mk_rec(p);
    rv = v; pc = rec.pc; instr = rec.instr; rd = rec.rd; we = rec.we;
    wdata = rec.wdata; flags = rec.flags; rdy = r; mode = md; clr = c; en = e;
    #1;
    if (va && r && !c) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL pop_empty actual=valid required=no_record");
      end else begin
        chk("pop_rec_a", reca, q[0]);
      end
    end
    if (c) begin
      q.delete(); m_drop = 0; m_stop = 1'b0;
    end else begin
      full = (q.size() == 4);
      mpop = r && (q.size() != 0);
      if (mpop) void'(q.pop_front());
      if (v && e) begin
        if (m_stop) begin
          m_drop++;
        end else if (!full || mpop) begin
          q.push_back(rec);
        end else begin
          case (md)
            2'd1: begin m_drop++; m_stop = 1'b1; end
            2'd2: begin void'(q.pop_front()); q.push_back(rec); m_drop++; end
            default: m_drop++;
          endcase
        end
      end
      if (m_drop > 65535) m_drop = 65535;
    end
    @(posedge clk);
    #1;
    check_state();
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    en = 1'b1; clr = 1'b0; rv = 1'b0; we = 1'b0; rdy = 1'b0; mode = 2'd0;
    pc = 32'd0; instr = 32'd0; wdata = 32'd0; rd = 6'd0; flags = 3'd0;

    #12;
    check_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Stream, ready high: each record appears one cycle after its push
    add(1'b1, 32'h80, 1'b1, 2'd0, 1'b0, 1'b1, 1, 0, 1'b0);
    add(1'b1, 32'h84, 1'b1, 2'd0, 1'b0, 1'b1, 1, 0, 1'b0);
    add(1'b1, 32'h88, 1'b1, 2'd0, 1'b0, 1'b1, 1, 0, 1'b0);
    add(1'b0, 32'h0,  1'b1, 2'd0, 1'b0, 1'b1, 0, 0, 1'b0);
    // Stream, ready low, 6 pushes
    for (int i = 0; i < 6; i++)
      add(1'b1, 32'h100 + 32'(4 * i), 1'b0, 2'd0, 1'b0, 1'b1,
          (i < 4) ? i + 1 : 4, (i < 4) ? 0 : i - 3, 1'b0);
    add(1'b1, 32'h1F0, 1'b0, 2'd0, 1'b0, 1'b0, 4, 2, 1'b0);   // disabled: ignored
    for (int i = 0; i < 4; i++) add(1'b0, 32'h0, 1'b1, 2'd0, 1'b0, 1'b1, 3 - i, 2, 1'b0);
    add(1'b1, 32'h1F4, 1'b0, 2'd0, 1'b1, 1'b1, 0, 0, 1'b0);   // clear beats retirement
    // Stop on full
    for (int i = 0; i < 5; i++)
      add(1'b1, 32'h200 + 32'(4 * i), 1'b0, 2'd1, 1'b0, 1'b1,
          (i < 4) ? i + 1 : 4, (i == 4) ? 1 : 0, i == 4);
    for (int i = 0; i < 4; i++) add(1'b0, 32'h0, 1'b1, 2'd1, 1'b0, 1'b1, 3 - i, 1, 1'b1);
    add(1'b1, 32'h214, 1'b1, 2'd1, 1'b0, 1'b1, 0, 2, 1'b1);
    add(1'b0, 32'h0, 1'b0, 2'd1, 1'b1, 1'b1, 0, 0, 1'b0);
    // Wrap: 8 pushes keep the last four
    for (int i = 0; i < 8; i++)
      add(1'b1, 32'(4 * i), 1'b0, 2'd2, 1'b0, 1'b1,
          (i < 4) ? i + 1 : 4, (i < 4) ? 0 : i - 3, 1'b0);
    for (int i = 0; i < 4; i++) add(1'b0, 32'h0, 1'b1, 2'd2, 1'b0, 1'b1, 3 - i, 4, 1'b0);
    add(1'b0, 32'h0, 1'b0, 2'd2, 1'b1, 1'b1, 0, 0, 1'b0);

    foreach (vecs[k]) begin
      step(vecs[k].v, vecs[k].pc, vecs[k].rdy, vecs[k].md, vecs[k].clr, vecs[k].en);
      chk("tbl_level", lvla, vecs[k].e_lvl);
      chk("tbl_drop", dropa, vecs[k].e_drop);
      chk("tbl_stop", stpa, vecs[k].e_stop);
    end

    // Full store, push and pop together, in every mode (3 behaves as stream)
    for (int m = 0; m < 4; m++) begin
      for (int i = 0; i < 4; i++) step(1'b1, 32'h300 + 32'(64 * m + 4 * i), 1'b0, 2'(m), 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
        step(1'b1, 32'h310 + 32'(64 * m + 4 * i), 1'b1, 2'(m), 1'b0, 1'b1);
        chk("fullpp_level", lvla, 4);
        chk("fullpp_drop", dropa, 0);
      end
      step(1'b1, 32'h330 + 32'(64 * m), 1'b0, 2'(m), 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1, 2'(m), 1'b0, 1'b1);
      step(1'b0, 32'h0, 1'b0, 2'(m), 1'b1, 1'b1);
    end

    // Drop counter saturation on the 2-bit instance
    for (int i = 0; i < 9; i++) step(1'b1, 32'h400 + 32'(4 * i), 1'b0, 2'd0, 1'b0, 1'b1);
    chk("sat_b", dropb, 2'd3);
    chk("sat_a", dropa, 16'd5);
    step(1'b1, 32'h440, 1'b0, 2'd0, 1'b0, 1'b1);
    chk("sat_b_hold", dropb, 2'd3);

    // Asynchronous reset mid-operation
    rv = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    q.delete(); m_drop = 0; m_stop = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 32'h500, 1'b0, 2'd0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 2'd0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
